// File: rtl/servo_pkg.sv
// Shared constants for the servo PWM decoder: duty width, direction codes and FSM states.
package servo_pkg;

   localparam int unsigned DUTY_W = 10;

   localparam logic [1:0] DIR_STOP = 2'b00;
   localparam logic [1:0] DIR_CCW  = 2'b01;
   localparam logic [1:0] DIR_CW   = 2'b10;

   typedef enum logic {
      StWaitEdge = 1'b0,
      StMeasure  = 1'b1
   } state_e;

endpackage

// File: rtl/pwm_ratio_divider.sv
// Restoring shift-subtract divider: quotient = floor(dividend * 2^DUTY_W / divisor),
// one quotient bit per cycle. Requires dividend < divisor.
module pwm_ratio_divider
   import servo_pkg::*;
#(
   parameter int unsigned CNT_W = 21
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              start_i,
   input  logic              abort_i,
   input  logic [CNT_W-1:0]  dividend_i,
   input  logic [CNT_W-1:0]  divisor_i,
   output logic [DUTY_W-1:0] quotient_o,
   output logic              done_o
);

   localparam logic [3:0] LastIter = 4'(DUTY_W - 1);

   logic [CNT_W-1:0]  rem_q, rem_d;
   logic [CNT_W-1:0]  div_q, div_d;
   logic [DUTY_W-2:0] quo_q, quo_d;
   logic [3:0]        iter_q, iter_d;
   logic              busy_q, busy_d;
   logic [CNT_W:0]    rem_sh;
   logic              fits;

   always_comb begin
      rem_sh     = {rem_q, 1'b0};
      fits       = (rem_sh >= {1'b0, div_q});
      rem_d      = rem_q;
      div_d      = div_q;
      quo_d      = quo_q;
      iter_d     = iter_q;
      busy_d     = busy_q;
      done_o     = 1'b0;
      // Final quotient bit is presented combinationally so the result lands on the done cycle.
      quotient_o = {quo_q, fits};
      if (abort_i) begin
         busy_d = 1'b0;
      end else if (start_i) begin
         rem_d  = dividend_i;
         div_d  = divisor_i;
         quo_d  = '0;
         iter_d = '0;
         busy_d = 1'b1;
      end else if (busy_q) begin
         rem_d  = fits ? CNT_W'(rem_sh - {1'b0, div_q}) : rem_sh[CNT_W-1:0];
         quo_d  = {quo_q[DUTY_W-3:0], fits};
         iter_d = iter_q + 4'd1;
         if (iter_q == LastIter) begin
            busy_d = 1'b0;
            done_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rem_q  <= '0;
         div_q  <= '0;
         quo_q  <= '0;
         iter_q <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         div_q  <= div_d;
         quo_q  <= quo_d;
         iter_q <= iter_d;
         busy_q <= busy_d;
      end
   end

endmodule

// File: rtl/servo_pwm_decoder.sv
// Measures an incoming servo PWM train: duty in 1/1024 of period, period, loss detection.
// Define SERVO_PWM_DIR_EN to decode wheel direction from duty; otherwise dir is tied to STOP.
module servo_pwm_decoder
   import servo_pkg::*;
#(
   parameter int unsigned CNT_W          = 21,
   parameter int unsigned MIN_PERIOD     = 100,
   parameter int unsigned TIMEOUT_CYCLES = 2_000_000,
   parameter int unsigned CENTER         = 28,
   parameter int unsigned DEADBAND       = 4
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              pwm_in,
   output logic [DUTY_W-1:0] duty,
   output logic              duty_valid,
   output logic [CNT_W-1:0]  period,
   output logic              signal_lost,
   output logic [1:0]        dir
);

   localparam logic [CNT_W-1:0] CntMax  = '1;
   localparam logic [CNT_W-1:0] MinP    = CNT_W'(MIN_PERIOD);
   localparam logic [CNT_W-1:0] Timeout = CNT_W'(TIMEOUT_CYCLES);

   logic              sync1_q, sync2_q, prev_q, rise;
   logic [CNT_W-1:0]  period_cnt_q, period_cnt_d, high_cnt_q, high_cnt_d;
   logic [CNT_W-1:0]  meas_period_q, meas_period_d;
   state_e            state_q, state_d;
   logic              div_start, timeout;
   logic              div_done;
   logic [DUTY_W-1:0] quotient;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [CNT_W-1:0]  period_q, period_d;
   logic              valid_q, valid_d, lost_q, lost_d;

   assign rise = sync2_q & ~prev_q;

   always_comb begin
      period_cnt_d = (period_cnt_q == CntMax) ? CntMax : period_cnt_q + 1'b1;
      high_cnt_d   = (sync2_q && high_cnt_q != CntMax) ? high_cnt_q + 1'b1 : high_cnt_q;
      if (rise) begin
         period_cnt_d = CNT_W'(1);
         high_cnt_d   = CNT_W'(1);
      end
   end

   always_comb begin
      state_d       = state_q;
      div_start     = 1'b0;
      timeout       = 1'b0;
      meas_period_d = meas_period_q;
      unique case (state_q)
         StWaitEdge: if (rise) state_d = StMeasure;
         StMeasure: begin
            // A rise beats a coincident timeout; short windows are glitches and only restart.
            if (rise) begin
               if (period_cnt_q >= MinP) begin
                  div_start     = 1'b1;
                  meas_period_d = period_cnt_q;
               end
            end else if (period_cnt_q == Timeout) begin
               timeout = 1'b1;
               state_d = StWaitEdge;
            end
         end
         default: state_d = StWaitEdge;
      endcase
   end

   pwm_ratio_divider #(
      .CNT_W (CNT_W)
   ) u_div (
      .clk        (clk),
      .reset_n    (reset_n),
      .start_i    (div_start),
      .abort_i    (timeout),
      .dividend_i (high_cnt_q),
      .divisor_i  (period_cnt_q),
      .quotient_o (quotient),
      .done_o     (div_done)
   );

   always_comb begin
      duty_d   = duty_q;
      period_d = period_q;
      lost_d   = lost_q;
      valid_d  = 1'b0;
      if (timeout) begin
         duty_d   = '0;
         period_d = '0;
         lost_d   = 1'b1;
      end else if (div_done) begin
         duty_d   = quotient;
         period_d = meas_period_q;
         lost_d   = 1'b0;
         valid_d  = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q       <= 1'b0;
         sync2_q       <= 1'b0;
         prev_q        <= 1'b0;
         period_cnt_q  <= '0;
         high_cnt_q    <= '0;
         meas_period_q <= '0;
         state_q       <= StWaitEdge;
         duty_q        <= '0;
         period_q      <= '0;
         valid_q       <= 1'b0;
         lost_q        <= 1'b1;
      end else begin
         sync1_q       <= pwm_in;
         sync2_q       <= sync1_q;
         prev_q        <= sync2_q;
         period_cnt_q  <= period_cnt_d;
         high_cnt_q    <= high_cnt_d;
         meas_period_q <= meas_period_d;
         state_q       <= state_d;
         duty_q        <= duty_d;
         period_q      <= period_d;
         valid_q       <= valid_d;
         lost_q        <= lost_d;
      end
   end

   assign duty        = duty_q;
   assign period      = period_q;
   assign duty_valid  = valid_q;
   assign signal_lost = lost_q;

`ifdef SERVO_PWM_DIR_EN
   localparam logic [DUTY_W-1:0] DutyHi = DUTY_W'(CENTER + DEADBAND);
   localparam logic [DUTY_W-1:0] DutyLo = DUTY_W'(CENTER - DEADBAND);

   logic [1:0] dir_q, dir_d;

   always_comb begin
      dir_d = dir_q;
      if (timeout) begin
         dir_d = DIR_STOP;
      end else if (div_done) begin
         if (quotient > DutyHi)      dir_d = DIR_CCW;
         else if (quotient < DutyLo) dir_d = DIR_CW;
         else                        dir_d = DIR_STOP;
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) dir_q <= DIR_STOP;
      else          dir_q <= dir_d;
   end

   assign dir = dir_q;
`else
   assign dir = DIR_STOP;
`endif

endmodule

// File: tb/tb_servo_pwm_decoder.sv
// Scoreboard bench for servo_pwm_decoder: stimulus queues expected results,
// a negedge monitor pops and compares on every duty_valid.
module tb_servo_pwm_decoder;
   import servo_pkg::*;

   localparam int unsigned CNT_W = 21;
   localparam int unsigned TMO   = 3000;
   localparam int unsigned LAT   = 13;  // pin rise to visible duty_valid, incl. synchronizer

   logic              clk = 1'b0;
   logic              reset_n = 1'b0;
   logic              pwm_in = 1'b0;
   logic [DUTY_W-1:0] duty;
   logic              duty_valid;
   logic [CNT_W-1:0]  period;
   logic              signal_lost;
   logic [1:0]        dir;

   typedef struct {
      int unsigned duty;
      int unsigned period;
      int unsigned dir;
      int unsigned at;
   } exp_t;

   exp_t        sb[$];
   int          n_vec  = 0;
   int          n_miss = 0;
   int unsigned cyc    = 0;

   servo_pwm_decoder #(
      .CNT_W          (CNT_W),
      .MIN_PERIOD     (100),
      .TIMEOUT_CYCLES (TMO),
      .CENTER         (28),
      .DEADBAND       (4)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .pwm_in      (pwm_in),
      .duty        (duty),
      .duty_valid  (duty_valid),
      .period      (period),
      .signal_lost (signal_lost),
      .dir         (dir)
   );

   always #10 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_miss++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic int unsigned dirx(input int unsigned d);
`ifdef SERVO_PWM_DIR_EN
      return d;
`else
      return 0;
`endif
   endfunction

   // Monitor: every duty_valid must match the oldest expectation, including its arrival cycle.
   always @(negedge clk) begin
      if (duty_valid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("unexpected_duty_valid", 1, 0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("duty", duty, e.duty);
            chk("period", period, e.period);
            chk("dir", dir, e.dir);
            chk("lost_on_valid", signal_lost, 0);
            chk("valid_cycle", cyc, e.at);
         end
      end
   end

   // One PWM period starting at this negedge; optionally expect the previous window's result.
   task automatic pulse(input int unsigned h, input int unsigned p, input bit push,
                        input int unsigned ed, input int unsigned ep, input int unsigned edir);
      pwm_in = 1'b1;
      if (push) sb.push_back('{ed, ep, dirx(edir), cyc + LAT});
      repeat (h) @(negedge clk);
      pwm_in = 1'b0;
      repeat (p - h) @(negedge clk);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      chk("rst_duty", duty, 0);
      chk("rst_valid", duty_valid, 0);
      chk("rst_period", period, 0);
      chk("rst_lost", signal_lost, 1);
      chk("rst_dir", dir, DIR_STOP);
      reset_n = 1'b1;
      repeat (2) @(negedge clk);

      // Nominal train: first rise only arms
      pulse(28, 1000, 0, 0, 0, 0);
      pulse(28, 1000, 1, 28, 1000, DIR_STOP);
      pulse(28, 1000, 1, 28, 1000, DIR_STOP);
      chk("lost_after_train", signal_lost, 0);

      // Direction decode above and below the deadband
      pulse(50, 1000, 1, 28, 1000, DIR_STOP);
      pulse(6, 1000, 1, 51, 1000, DIR_CCW);
      pulse(28, 1000, 1, 6, 1000, DIR_CW);

      // Input held low: outputs hold, then timeout clears them
      repeat (500) @(negedge clk);
      chk("hold_lost", signal_lost, 0);
      chk("hold_duty", duty, 6);
      chk("hold_dir", dir, dirx(DIR_CW));
      repeat (1600) @(negedge clk);
      chk("tmo_lost", signal_lost, 1);
      chk("tmo_duty", duty, 0);
      chk("tmo_period", period, 0);
      chk("tmo_dir", dir, DIR_STOP);
      pulse(28, 1000, 0, 0, 0, 0);
      pulse(28, 1000, 1, 28, 1000, DIR_STOP);
      chk("recover_lost", signal_lost, 0);

      // Glitch pair: two 50-cycle windows are dropped, next full window is reported
      pulse(28, 50, 1, 28, 1000, DIR_STOP);
      pulse(10, 50, 0, 0, 0, 0);
      pulse(50, 1000, 0, 0, 0, 0);
      pulse(28, 1000, 1, 51, 1000, DIR_CCW);

      // Reset mid-divide: result is discarded, outputs return to reset values
      pwm_in = 1'b1;
      repeat (7) @(negedge clk);
      reset_n = 1'b0;
      #1;
      chk("mid_rst_duty", duty, 0);
      chk("mid_rst_valid", duty_valid, 0);
      chk("mid_rst_period", period, 0);
      chk("mid_rst_lost", signal_lost, 1);
      chk("mid_rst_dir", dir, DIR_STOP);
      repeat (3) @(negedge clk);
      pwm_in = 1'b0;
      repeat (3) @(negedge clk);
      reset_n = 1'b1;
      repeat (20) @(negedge clk);
      pulse(28, 1000, 0, 0, 0, 0);
      chk("post_rst_arm_lost", signal_lost, 1);
      pulse(50, 1000, 1, 28, 1000, DIR_STOP);
      repeat (50) @(negedge clk);
      chk("final_duty", duty, 28);
      chk("final_lost", signal_lost, 0);
      chk("pending_expectations", sb.size(), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
